// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a 2-entry skid buffer.
// Optional perf counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 69,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  drop_cnt
`endif
);

  if (CTRL_W < 1 || DATA_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("pipe_stage_skid: widths must be >= 1");
  end

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              ready_q;
  logic              push;
  logic              pop;

  assign in_ready  = ready_q;
  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign occupancy = {skid_valid, main_valid & ~skid_valid};
  assign push      = in_valid & ready_q;
  assign pop       = main_valid & out_ready;

  // Two-entry storage; MAIN feeds the outputs, SKID catches the in-flight entry.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      ready_q    <= 1'b1;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      ready_q    <= 1'b1;
    end else begin
      unique case (1'b1)
        !main_valid: begin
          if (push) begin
            main_valid <= 1'b1;
            main_ctrl  <= in_ctrl;
            main_data  <= in_data;
          end
        end
        main_valid && !skid_valid: begin
          if (push && pop) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (push) begin
            skid_valid <= 1'b1;
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
            ready_q    <= 1'b0;
          end else if (pop) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
          end
        end
        default: begin
          if (pop) begin
            main_ctrl  <= skid_ctrl;
            main_data  <= skid_data;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            ready_q    <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [1:0]     drop_n;
  logic [CNT_W:0] drop_sum;

  // Entries killed by flush: held ones only, minus a head consumed that cycle.
  always_comb begin
    drop_n   = {1'b0, main_valid & ~out_ready} + {1'b0, skid_valid};
    drop_sum = {1'b0, drop_cnt} + (CNT_W + 1)'(drop_n);
  end

  // Saturating stall and drop counters; cleared by reset only.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (main_valid && !out_ready && !(&stall_cnt))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush)
        drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end
  end
`endif

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised elastic pipeline-stage register; the next generation of the fixed EX/MEM latch.
- Carries a control field (write-enable type bits) and a data field between two pipeline stages using a valid/ready handshake.
- Uses a 2-entry skid buffer, so `in_ready` is registered and full throughput (1 transfer/cycle) is kept under backpressure.
- Synchronous flush inserts bubbles with all control bits cleared; usable for EX/MEM, MEM/WB or any later stage.

Parameters:
- CTRL_W, 4: control field width (e.g. WB, RegWrite, MRead, MWrite); must be ≥1.
- DATA_W, 69: data field width (e.g. ALU result 32 + store data 32 + dest reg 5); must be ≥1.
- CNT_W, 16: perf counter width; used only when PIPE_STAGE_PERF_EN is defined.

Ports:
- clock  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- flush  input  1  synchronous flush; discards all held and incoming entries
- in_valid  input  1  upstream has an entry
- in_ready  output  1  stage can accept; registered
- in_ctrl  input  CTRL_W  upstream control bits
- in_data  input  DATA_W  upstream payload
- out_valid  output  1  stage holds an entry for downstream
- out_ready  input  1  downstream accepts
- out_ctrl  output  CTRL_W  control of head entry; forced 0 when out_valid=0
- out_data  output  DATA_W  payload of head entry; don't-care when out_valid=0
- occupancy  output  2  entries held, 0..2
- stall_cnt  output  CNT_W  (PIPE_STAGE_PERF_EN only) backpressure cycles
- drop_cnt  output  CNT_W  (PIPE_STAGE_PERF_EN only) valid entries killed by flush

Behaviour:
- Reset is asynchronous and active-high. All registers clear: main and skid valid=0, ctrl=0, data=0, occupancy=0, in_ready=1, out_valid=0, out_ctrl=0, counters=0.
- Storage is two entries: MAIN, which drives the outputs, and SKID. in_ready = ~skid_valid, taken from a register with no combinational path from out_ready. push = in_valid & in_ready. pop = out_valid & out_ready.
- States, encoded by occupancy:
  - EMPTY, occupancy 0:
    - push → MAIN←in, go to ONE.
    - else stay in EMPTY.
  - ONE, occupancy 1:
    - push & pop → MAIN←in, stay in ONE.
    - push only → SKID←in, go to FULL.
    - pop only → go to EMPTY.
    - neither → hold.
  - FULL, occupancy 2 (in_ready=0, so push is impossible):
    - pop → MAIN←SKID, go to ONE.
    - no pop → hold both entries.
- Latency: entry accepted at edge N appears on out_* after edge N (1-cycle latency). Order is strictly FIFO.
- A sustained in_valid=out_ready=1 transfers 1 entry/cycle.
- If out_ready drops for one cycle, the entry in flight lands in SKID and is not lost. in_ready falls the cycle after.
- Flush has the highest priority, above push and pop in the same cycle:
  - Both valid bits clear and both ctrl fields zero; data registers may hold their value.
  - The incoming entry is discarded.
  - Next state is EMPTY, with in_ready=1 after the edge.
  - The downstream entry presented in the flush cycle still counts as popped if out_ready=1 (downstream already consumed it).
- Flush while EMPTY: no effect.
- Bubble rule: whenever out_valid=0, out_ctrl = 0. No spurious register/memory writes downstream.
- Inputs are ignored when in_ready=0 (no overwrite of SKID).
- Reset mid-transfer: state is lost immediately and asynchronously; outputs go to reset values.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid=1 & out_ready=0.
  - drop_cnt adds the number of valid entries (0..2) discarded by each flush, counting held entries only, not the incoming one.
  - Both counters saturate at all-ones and clear on rst only.
- Undefined: stall_cnt and drop_cnt ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then stream ctrl=4'b1010 with data 1..8 on consecutive cycles, out_ready=1 → out_valid rises 1 cycle after the first push; data 1..8 on consecutive cycles; in_ready stays 1; occupancy ≤1.
- Stream data 1..4, drop out_ready for 2 cycles while data=2 is pending → occupancy reaches 2, in_ready=0 for 2 cycles; output order is 1,2,3,4 with no loss or duplication.
- Reach FULL (entries 5,6), then assert flush with in_valid=1 (data 7) → next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; 7 never appears; drop_cnt=2 if PERF enabled.
- Assert flush and out_ready together in the ONE state (entry 9) → 9 is counted as consumed that cycle; next cycle EMPTY; drop_cnt unchanged.
- Assert rst asynchronously mid-stream between clock edges → out_valid and out_ctrl drop to 0 and in_ready to 1 without a clock edge; counters read 0.
- PERF enabled, CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt saturates at 15.
